// File: rtl/rv16_mul_arbiter.sv
// rv16_mul_arbiter
//
// Shares one multi-cycle multiplier between NUM_REQ requesters. Requests are
// granted round-robin in IDLE. The granted operand pair is latched and a
// single-cycle start pulse is issued once the multiplier is not busy. The
// sequencer then waits for mul_done, or for TIMEOUT cycles, and returns the
// product, or an error, to the granted requester. Only one multiplication is
// in flight at a time.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (ready one-hot or zero)
//   req_op_a/req_op_b      packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready  per-requester response handshake (valid one-hot or zero)
//   resp_result/resp_err   shared product and timeout flag, held while resp_valid
//   mul_start              one-cycle start pulse to the multiplier
//   mul_op_a/mul_op_b      latched operands, stable from ISSUE until RESP exits
//   mul_result/mul_done    product and completion pulse from the multiplier
//   mul_busy               multiplier cannot accept a start
module rv16_mul_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_op_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_op_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_op_a,
  output logic [WIDTH-1:0]         mul_op_b,
  input  logic [WIDTH-1:0]         mul_result,
  input  logic                     mul_done,
  input  logic                     mul_busy
);

  localparam int unsigned GW = (NUM_REQ > 2) ? 2 : 1;

  typedef logic [GW-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             state_q;
  idx_t               last_grant_q;
  idx_t               grant_q;
  logic [7:0]         cnt_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [WIDTH-1:0]   resp_result_q;
  logic               resp_err_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;

  idx_t               win_idx;
  logic               win_found;
  logic [31:0]        scan_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic               accept;
  logic               timeout_hit;

  // Round-robin search: first valid requester starting just after last_grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!win_found && req_valid[scan_idx[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[GW-1:0];
      end
    end
  end

  assign win_oh   = NUM_REQ'(1) << win_idx;
  assign grant_oh = NUM_REQ'(1) << grant_q;

  // Ready is a pure decode of IDLE plus the winner; gated by rst_n so that it
  // reads zero while reset is held even if requesters keep valid high.
  assign req_ready = (rst_n && (state_q == StIdle) && win_found) ? win_oh : '0;
  assign accept    = |(req_valid & req_ready);

  // The counter holds the number of WAIT cycles already spent; the
  // TIMEOUT-th WAIT cycle is the last one.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Start is decoded from ISSUE so that mul_busy is honoured in the same cycle.
  assign mul_start = (state_q == StIssue) && !mul_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= idx_t'(NUM_REQ - 1);
      grant_q       <= '0;
      cnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_a_q  <= req_op_a[32'(win_idx) * WIDTH +: WIDTH];
            op_b_q  <= req_op_b[32'(win_idx) * WIDTH +: WIDTH];
            grant_q <= win_idx;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!mul_busy) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          // A done coinciding with the last WAIT cycle still wins.
          if (mul_done) begin
            resp_result_q <= mul_result;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= grant_oh;
            state_q       <= StResp;
          end else if (timeout_hit) begin
            resp_result_q <= '0;
            resp_err_q    <= 1'b1;
            resp_valid_q  <= grant_oh;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;
  assign mul_op_a    = op_a_q;
  assign mul_op_b    = op_b_q;

endmodule

// File: tb/tb_rv16_mul_arbiter.sv
// Testbench for rv16_mul_arbiter: directed scenarios followed by randomized
// transactions. The bench plays both the requesters and the multiplier; the
// expected grant, product and timeout outcome come from a transaction-level
// model (round-robin pick over a mask, plain multiplication, WAIT-cycle budget).
module tb_rv16_mul_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 15;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_op_a;
  logic [N*W-1:0]   req_op_b;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready;
  logic [W-1:0]     resp_result;
  logic             resp_err;
  logic             mul_start;
  logic [W-1:0]     mul_op_a;
  logic [W-1:0]     mul_op_b;
  logic [W-1:0]     mul_result;
  logic             mul_done;
  logic             mul_busy;

  int               n_total;
  int               n_bad;
  int               lg;
  logic [W-1:0]     op_a_m [N];
  logic [W-1:0]     op_b_m [N];

  rv16_mul_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op_a   (req_op_a),
    .req_op_b   (req_op_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .mul_start  (mul_start),
    .mul_op_a   (mul_op_a),
    .mul_op_b   (mul_op_b),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .mul_busy   (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      req_op_a[i*W +: W] = op_a_m[i];
      req_op_b[i*W +: W] = op_b_m[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, ".req_ready"},   64'(req_ready),   64'd0);
    chk_eq({tag, ".resp_valid"},  64'(resp_valid),  64'd0);
    chk_eq({tag, ".resp_result"}, 64'(resp_result), 64'd0);
    chk_eq({tag, ".resp_err"},    64'(resp_err),    64'd0);
    chk_eq({tag, ".mul_start"},   64'(mul_start),   64'd0);
    chk_eq({tag, ".mul_op_a"},    64'(mul_op_a),    64'd0);
    chk_eq({tag, ".mul_op_b"},    64'(mul_op_b),    64'd0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    mul_done   = 1'b0;
    mul_busy   = 1'b0;
    resp_ready = '0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    lg    = N - 1;
  endtask

  // One full transaction, entered and left at a falling edge with the DUT idle.
  // done_dly: WAIT cycle (1-based) carrying mul_done; beyond TO means never.
  task automatic run_txn(input logic [N-1:0] mask, input int busy_n, input int done_dly,
                         input int bp_n, input bit late_done);
    int           g;
    int           nwait;
    bit           tmo;
    logic [N-1:0] goh;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] er;
    g     = rr_pick(mask, lg);
    goh   = N'(1) << g;
    ea    = op_a_m[g];
    eb    = op_b_m[g];
    tmo   = (done_dly > TO);
    nwait = tmo ? TO : done_dly;
    if (tmo) er = '0;
    else     er = ea * eb;

    apply_ops();
    req_valid  = mask;
    mul_busy   = (busy_n > 0);
    mul_done   = 1'($urandom_range(0, 1));   // stray done in IDLE is ignored
    mul_result = $urandom;
    resp_ready = N'($urandom) & ~goh;
    #1;
    chk_eq("grant", 64'(req_ready), 64'(goh));
    chk_eq("idle.resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    mul_done  = 1'b0;
    // Change the winner's inputs: the latched operands must not follow.
    op_a_m[g] = $urandom;
    op_b_m[g] = $urandom;
    apply_ops();
    for (int i = 0; i < busy_n; i++) begin
      #1;
      chk_eq("busy.mul_start", 64'(mul_start), 64'd0);
      chk_eq("busy.req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    mul_busy = 1'b0;
    #1;
    chk_eq("issue.mul_start", 64'(mul_start), 64'd1);
    chk_eq("issue.mul_op_a",  64'(mul_op_a),  64'(ea));
    chk_eq("issue.mul_op_b",  64'(mul_op_b),  64'(eb));
    chk_eq("issue.req_ready", 64'(req_ready), 64'd0);
    for (int w = 1; w <= nwait; w++) begin
      @(negedge clk);
      mul_done   = (w == done_dly);
      mul_result = (w == done_dly) ? W'(ea * eb) : W'($urandom);
      #1;
      chk_eq("wait.mul_start",  64'(mul_start),  64'd0);
      chk_eq("wait.resp_valid", 64'(resp_valid), 64'd0);
      chk_eq("wait.req_ready",  64'(req_ready),  64'd0);
      chk_eq("wait.mul_op_a",   64'(mul_op_a),   64'(ea));
    end
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    chk_eq("resp.valid",  64'(resp_valid),  64'(goh));
    chk_eq("resp.result", 64'(resp_result), 64'(er));
    chk_eq("resp.err",    64'(resp_err),    64'(tmo));
    for (int i = 0; i < bp_n; i++) begin
      if (late_done && i == 0) begin
        mul_done   = 1'b1;
        mul_result = $urandom | 32'h1;
      end
      @(negedge clk);
      mul_done = 1'b0;
      #1;
      chk_eq("hold.valid",     64'(resp_valid),  64'(goh));
      chk_eq("hold.result",    64'(resp_result), 64'(er));
      chk_eq("hold.err",       64'(resp_err),    64'(tmo));
      chk_eq("hold.req_ready", 64'(req_ready),   64'd0);
      chk_eq("hold.mul_start", 64'(mul_start),   64'd0);
      chk_eq("hold.mul_op_b",  64'(mul_op_b),    64'(eb));
    end
    resp_ready = resp_ready | goh;
    #1 chk_eq("hs.req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    resp_ready = '0;
    lg         = g;
    #1;
    chk_eq("post.resp_valid", 64'(resp_valid), 64'd0);
    // Back in IDLE with the same requests held: next winner follows rotation.
    chk_eq("post.grant", 64'(req_ready), 64'(N'(1) << rr_pick(mask, lg)));
  endtask

  initial begin
    logic [N-1:0] mask;
    int           r;
    int           dd;
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < N; i++) begin
      op_a_m[i] = '0;
      op_b_m[i] = '0;
    end
    mul_result = '0;
    apply_ops();
    do_reset();

    // Single request, done 3 cycles after start: 7*6.
    op_a_m[0] = 32'h7;
    op_b_m[0] = 32'h6;
    run_txn(2'b01, 0, 3, 0, 1'b0);

    // Contention from reset: grants 0, 1, 0.
    @(negedge clk);
    do_reset();
    op_a_m[0] = 32'h3;
    op_b_m[0] = 32'h5;
    op_a_m[1] = 32'h0001_0000;
    op_b_m[1] = 32'h10;
    run_txn(2'b11, 0, 2, 0, 1'b0);
    run_txn(2'b11, 0, 4, 0, 1'b0);
    run_txn(2'b11, 0, 1, 0, 1'b0);

    // Response backpressure for 10 cycles.
    op_a_m[0] = 32'h1234;
    op_b_m[0] = 32'h10;
    run_txn(2'b01, 0, 3, 10, 1'b0);

    // Busy stall of 4 cycles at ISSUE.
    run_txn(2'b01, 4, 3, 0, 1'b0);

    // Timeout, then a late done while the response is held.
    run_txn(2'b01, 0, 1000, 3, 1'b1);
    // Done on the very last WAIT cycle beats the timeout.
    run_txn(2'b10, 0, TO, 1, 1'b0);

    // Reset one cycle after the start pulse.
    op_a_m[0] = 32'h55 | 32'h1;
    op_b_m[0] = 32'h77;
    apply_ops();
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    #1 chk_eq("rst6.mul_start", 64'(mul_start), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_all_zero("rst6");
    mul_done   = 1'b1;
    mul_result = 32'hdead_beef;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    mul_done  = 1'b0;
    lg        = N - 1;
    for (int i = 0; i < 20; i++) begin
      mul_done = (i == 3);
      @(negedge clk);
      #1;
      chk_eq("rst6.no_resp",  64'(resp_valid), 64'd0);
      chk_eq("rst6.no_start", 64'(mul_start),  64'd0);
    end
    mul_done  = 1'b0;
    op_a_m[0] = 32'h9;
    op_b_m[0] = 32'h9;
    run_txn(2'b11, 0, 2, 0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a_m[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        op_b_m[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      r    = $urandom_range(0, 9);
      if (r == 0)      dd = TO + 1 + $urandom_range(0, 2);
      else if (r == 1) dd = TO;
      else             dd = $urandom_range(1, 6);
      run_txn(mask, $urandom_range(0, 3), dd, $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rv16_mul_arbiter.md
Name: rv16_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle rv16 multiplier unit between NUM_REQ requesters, such as the integer pipeline and a debug/coprocessor port. It accepts operand pairs over per-requester valid/ready handshakes and issues a single-cycle start pulse to the multiplier. It waits for done, or for a watchdog timeout, and returns the product to the granted requester over a valid/ready response channel. Only one multiplication is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
WIDTH, 32, operand and result width.
TIMEOUT, 15, maximum WAIT cycles before an aborted result is returned; legal range 1..255.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
req_op_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
req_op_b  input  NUM_REQ*WIDTH  packed operand B; same packing as req_op_a.
resp_valid  output  NUM_REQ  per-requester response valid; one-hot or zero.
resp_ready  input  NUM_REQ  per-requester response accept.
resp_result  output  WIDTH  product, shared by all requesters; meaningful only while any resp_valid is high.
resp_err  output  1  high with resp_valid when the operation timed out.
mul_start  output  1  single-cycle start pulse to the multiplier.
mul_op_a  output  WIDTH  operand A to the multiplier.
mul_op_b  output  WIDTH  operand B to the multiplier.
mul_result  input  WIDTH  multiplier product; sampled on mul_done.
mul_done  input  1  multiplier completion pulse.
mul_busy  input  1  multiplier busy.

Behaviour:
- Reset values (async, rst_n low): state=IDLE; req_ready=0; resp_valid=0; resp_result=0; resp_err=0; mul_start=0; mul_op_a=0; mul_op_b=0; last_grant=NUM_REQ-1 (requester 0 has highest priority first); timeout counter=0.
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is the first requester with req_valid high, searching cyclically from last_grant+1.
  - req_ready[g] is driven combinationally high for the winner only; all other ready bits are 0. If no requester is valid, all ready bits are 0.
  - When req_valid[g] and req_ready[g] are both high: latch a_g into mul_op_a and b_g into mul_op_b, register g, go to ISSUE.
  - Accept-to-start latency is 1 cycle.
- ISSUE:
  - If mul_busy is low, mul_start=1 for exactly this cycle, clear the counter, go to WAIT.
  - If mul_busy is high, mul_start=0 and stay in ISSUE; no timeout applies in this state.
- WAIT:
  - mul_start=0; mul_op_a and mul_op_b are held stable from ISSUE until RESP is exited.
  - The counter increments each cycle.
  - On mul_done: resp_result <= mul_result, resp_err <= 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT: resp_result <= 0, resp_err <= 1, go to RESP.
  - If mul_done and timeout occur in the same cycle, mul_done wins.
- RESP:
  - resp_valid[g]=1, registered and held together with resp_result and resp_err until resp_ready[g] is high.
  - On handshake: resp_valid <= 0, last_grant <= g, go to IDLE.
  - A new request cannot be accepted in the handshake cycle; the minimum gap between accepts is therefore 1 idle cycle.
- mul_done pulses outside WAIT are ignored, including a stale done arriving after a timeout.
- req_ready is never asserted outside IDLE. A requester may drop req_valid before it is accepted without side effects.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... with no starvation.
- Reset asserted mid-operation (any state) returns all outputs to reset values immediately. The in-flight operation is lost, and no response is produced after reset.

Test Plan:
1. Single request, normal path: requester 0 sends a=0x0000_0007, b=0x0000_0006 with resp_ready=1 and a model that raises mul_done 3 cycles after start.
   -> mul_start pulses once, 1 cycle after accept; resp_valid=01; resp_result=0x0000_002A; resp_err=0.
2. Contention: both requesters hold req_valid from reset, with operands 3*5 and 0x10000*0x10.
   -> requester 0 is granted first and returns 0x0000_000F; requester 1 is granted next and returns 0x0010_0000; a third round grants requester 0 again.
3. Response backpressure: resp_ready[0]=0 for 10 cycles after resp_valid rises.
   -> resp_valid and resp_result stay stable; req_ready stays 0; no second mul_start is issued.
4. Busy stall: mul_busy is held high for 4 cycles at ISSUE entry.
   -> mul_start stays 0 for those 4 cycles, then pulses exactly once.
5. Timeout: the model never asserts mul_done, with TIMEOUT=15.
   -> resp_valid rises 15 cycles after start with resp_result=0 and resp_err=1; a late mul_done pulse is then ignored.
6. Reset mid-WAIT: deassert-then-reassert rst_n low 1 cycle after mul_start.
   -> all outputs return to 0 immediately and no resp_valid appears; the next request is processed normally with requester 0 priority.
